maindec_mc: RTL and testbench

//  Multicycle successor of the single-cycle main decoder: Moore/Mealy FSM generating MIPS datapath controls per step.

---
 rtl/maindec_mc_if.sv | 49 ++++
 rtl/maindec_mc.sv | 251 +++++++++++++++++++++++++
 tb/tb_maindec_mc.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/maindec_mc_if.sv
// Control bundle between the multicycle main decoder and the MIPS datapath.
// master: decoder side (takes op/mem_ready, drives step controls and status).
// slave : datapath side (drives op/mem_ready, consumes controls and status).
// Optional feature macro: MAINDEC_MC_BNE_EN adds the branch_ne control.
interface maindec_mc_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       op;
  logic             mem_ready;
  logic             pcwrite;
  logic             branch;
  logic             iord;
  logic             memwrite;
  logic             irwrite;
  logic             regdst;
  logic             memtoreg;
  logic             regwrite;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       pcsrc;
  logic [1:0]       aluop;
  logic [3:0]       state;
  logic             illegal_op;
  logic             mem_timeout;
  logic [CNT_W-1:0] instr_count;
`ifdef MAINDEC_MC_BNE_EN
  logic             branch_ne;
`endif

  modport master (
    input  op, mem_ready,
`ifdef MAINDEC_MC_BNE_EN
    output branch_ne,
`endif
    output pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg,
           regwrite, alusrca, alusrcb, pcsrc, aluop, state, illegal_op,
           mem_timeout, instr_count
  );

  modport slave (
    output op, mem_ready,
`ifdef MAINDEC_MC_BNE_EN
    input  branch_ne,
`endif
    input  pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg,
           regwrite, alusrca, alusrcb, pcsrc, aluop, state, illegal_op,
           mem_timeout, instr_count
  );
endinterface

// File: rtl/maindec_mc.sv
// Multicycle MIPS main decoder FSM (RTYPE/LW/SW/BEQ/ADDI/J) with memory-ready
// wait + timeout, illegal-op pulse and retired-instruction counter.
// Ports: clk, reset (sync, active-high), bus (maindec_mc_if.master: op and
// mem_ready in; step controls, state, illegal_op, mem_timeout, instr_count out).
// Latency: controls are a function of the current state (FETCH strobes also
// follow mem_ready); status flags/counter are registered.
// Backpressure: FETCH/MEMRD/MEMWR hold until mem_ready or MAX_WAIT idle cycles.
// Macro MAINDEC_MC_BNE_EN: decode BNE (000101) through the branch state and
// add the branch_ne output; otherwise 000101 is an illegal opcode.
module maindec_mc #(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  maindec_mc_if.master  bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MAINDEC_MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_mem_timeout;
  logic              r_illegal_op;
  logic [CNT_W-1:0]  r_instr_count;

  logic              w_mem_ready;
  logic              w_wait_state;
  logic              w_timeout;
  logic              w_retire;
  logic              w_illegal;
  logic              w_pcwrite, w_branch, w_iord, w_memwrite, w_irwrite;
  logic              w_regdst, w_memtoreg, w_regwrite, w_alusrca;
  logic [1:0]        w_alusrcb, w_pcsrc, w_aluop;
`ifdef MAINDEC_MC_BNE_EN
  // BEQ and BNE share the branch state; remember which one was decoded so
  // op is only looked at during DECODE.
  logic              r_is_bne;
  logic              w_is_bne;
  logic              w_branch_ne;
`endif

  assign w_mem_ready  = bus.mem_ready;
  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                        (r_state == S_MEMWR);
  // mem_ready wins over an expiring wait budget.
  assign w_timeout    = w_wait_state && !w_mem_ready &&
                        (r_wait_cnt == WAIT_W'(MAX_WAIT));

  always_comb begin
    w_next     = r_state;
    w_retire   = 1'b0;
    w_illegal  = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_iord     = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_pcsrc    = 2'b00;
    w_aluop    = 2'b00;
`ifdef MAINDEC_MC_BNE_EN
    w_is_bne    = 1'b0;
    w_branch_ne = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        w_alusrcb = 2'b01;
        // PC/IR only load in the cycle memory delivers the instruction.
        w_pcwrite = w_mem_ready;
        w_irwrite = w_mem_ready;
        if (w_mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_alusrcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BEQ;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
`ifdef MAINDEC_MC_BNE_EN
          OP_BNE: begin
            w_next   = S_BEQ;
            w_is_bne = 1'b1;
          end
`endif
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_iord = 1'b1;
        if (w_mem_ready)    w_next = S_MEMWB;
        else if (w_timeout) w_next = S_FETCH;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
        w_next     = S_FETCH;
        w_retire   = 1'b1;
      end
      S_MEMWR: begin
        // Write strobe held for the whole wait; memory commits on mem_ready.
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
        if (w_mem_ready) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end else if (w_timeout) begin
          w_next   = S_FETCH;
        end
      end
      S_EXEC: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
        w_retire   = 1'b1;
      end
      S_BEQ: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b01;
        w_pcsrc   = 2'b01;
`ifdef MAINDEC_MC_BNE_EN
        w_branch    = !r_is_bne;
        w_branch_ne = r_is_bne;
`else
        w_branch  = 1'b1;
`endif
        w_next    = S_FETCH;
        w_retire  = 1'b1;
      end
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
        w_retire   = 1'b1;
      end
      S_JUMP: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = S_FETCH;
        w_retire  = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
    // A reset or timeout cycle must not commit any architectural write.
    if (reset || w_timeout) begin
      w_pcwrite  = 1'b0;
      w_branch   = 1'b0;
      w_memwrite = 1'b0;
      w_irwrite  = 1'b0;
      w_regwrite = 1'b0;
`ifdef MAINDEC_MC_BNE_EN
      w_branch_ne = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
      r_illegal_op  <= 1'b0;
      r_instr_count <= '0;
`ifdef MAINDEC_MC_BNE_EN
      r_is_bne      <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_next != r_state || w_timeout)
        r_wait_cnt <= '0;
      else if (w_wait_state && !w_mem_ready)
        r_wait_cnt <= r_wait_cnt + 1'b1;
      r_mem_timeout <= r_mem_timeout | w_timeout;
      r_illegal_op  <= w_illegal;
      if (w_retire) r_instr_count <= r_instr_count + 1'b1;
`ifdef MAINDEC_MC_BNE_EN
      if (r_state == S_DECODE) r_is_bne <= w_is_bne;
`endif
    end
  end

  assign bus.pcwrite     = w_pcwrite;
  assign bus.branch      = w_branch;
  assign bus.iord        = w_iord;
  assign bus.memwrite    = w_memwrite;
  assign bus.irwrite     = w_irwrite;
  assign bus.regdst      = w_regdst;
  assign bus.memtoreg    = w_memtoreg;
  assign bus.regwrite    = w_regwrite;
  assign bus.alusrca     = w_alusrca;
  assign bus.alusrcb     = w_alusrcb;
  assign bus.pcsrc       = w_pcsrc;
  assign bus.aluop       = w_aluop;
  assign bus.state       = r_state;
  assign bus.illegal_op  = r_illegal_op;
  assign bus.mem_timeout = r_mem_timeout;
  assign bus.instr_count = r_instr_count;
`ifdef MAINDEC_MC_BNE_EN
  assign bus.branch_ne   = w_branch_ne;
`endif

endmodule

// File: tb/tb_maindec_mc.sv
// Bench for maindec_mc: directed instruction sequences push one expected
// record per cycle; an independent monitor pops and compares at negedge.
module tb_maindec_mc;
  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3;
  localparam int S_MEMWB = 4, S_MEMWR = 5, S_EXEC = 6, S_ALUWB = 7;
  localparam int S_BEQ = 8, S_ADDIEX = 9, S_ADDIWB = 10, S_JUMP = 11;

  typedef struct packed {
    logic       pcwrite, branch, iord, memwrite, irwrite;
    logic       regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc, aluop;
  } ctrl_t;

  typedef struct packed {
    logic [3:0]       st;
    ctrl_t            c;
    logic             bne;
    logic             ill;
    logic             to;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  maindec_mc_if #(.CNT_W(CNT_W)) bus();
  maindec_mc #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t             q[$];
  int               n_cmp = 0;
  int               n_fail = 0;
  int               cyc_idx = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic             exp_ill = 1'b0;
  logic             exp_to = 1'b0;
  logic             exp_bne = 1'b0;
  logic             rst_v = 1'b0;

  // Control table per state; sup kills the write strobes (reset/timeout).
  function automatic ctrl_t exp_ctrl(input int st, input bit rdy, input bit bne, input bit sup);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH:  begin c.alusrcb = 2'b01; c.pcwrite = rdy; c.irwrite = rdy; end
      S_DECODE: c.alusrcb = 2'b11;
      S_MEMADR: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEMRD:  c.iord = 1'b1;
      S_MEMWB:  begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      S_MEMWR:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
      S_EXEC:   begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      S_ALUWB:  begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      S_BEQ:    begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = !bne; end
      S_ADDIEX: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_ADDIWB: c.regwrite = 1'b1;
      S_JUMP:   begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default:  c = '0;
    endcase
    if (sup) begin
      c.pcwrite = 1'b0; c.branch = 1'b0; c.memwrite = 1'b0;
      c.irwrite = 1'b0; c.regwrite = 1'b0;
    end
    return c;
  endfunction

  // One clock of stimulus: drive inputs, queue what the DUT must show.
  task automatic cyc(input int st, input bit rdy, input logic [5:0] opv, input bit to);
    exp_t e;
    logic [31:0] stv;
    @(posedge clk);
    #1;
    reset         = rst_v;
    bus.mem_ready = rdy;
    bus.op        = opv;
    stv   = st;
    e.st  = stv[3:0];
    e.c   = exp_ctrl(st, rdy, (st == S_BEQ) && exp_bne, rst_v || to);
    e.bne = (st == S_BEQ) && exp_bne && !rst_v;
    e.ill = exp_ill;
    e.to  = exp_to;
    e.cnt = exp_cnt;
    q.push_back(e);
  endtask

  task automatic fetch_dec(input logic [5:0] opv);
    cyc(S_FETCH, 1'b1, opv, 1'b0);
    cyc(S_DECODE, 1'b1, opv, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc_idx, act, expv);
    end
  endtask

  // Monitor: independent of stimulus, compares whatever record is queued.
  initial begin
    exp_t  e;
    ctrl_t act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {bus.pcwrite, bus.branch, bus.iord, bus.memwrite, bus.irwrite,
               bus.regdst, bus.memtoreg, bus.regwrite, bus.alusrca,
               bus.alusrcb, bus.pcsrc, bus.aluop};
        chk("state", 32'(bus.state), 32'(e.st));
        chk("ctrl", 32'(act), 32'(e.c));
        chk("illegal_op", 32'(bus.illegal_op), 32'(e.ill));
        chk("mem_timeout", 32'(bus.mem_timeout), 32'(e.to));
        chk("instr_count", 32'(bus.instr_count), 32'(e.cnt));
`ifdef MAINDEC_MC_BNE_EN
        chk("branch_ne", 32'(bus.branch_ne), 32'(e.bne));
`endif
        cyc_idx++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.mem_ready = 1'b0;
    bus.op        = OP_RTYPE;
    repeat (2) @(posedge clk);

    // Post-reset idle FETCH: only alusrcb, flags and counter clear.
    cyc(S_FETCH, 1'b0, OP_RTYPE, 1'b0);

    // RTYPE: 0,1,6,7
    fetch_dec(OP_RTYPE);
    cyc(S_EXEC, 1'b1, OP_RTYPE, 1'b0);
    cyc(S_ALUWB, 1'b1, OP_RTYPE, 1'b0);
    exp_cnt++;

    // LW with three wait cycles in MEMRD
    fetch_dec(OP_LW);
    cyc(S_MEMADR, 1'b1, OP_LW, 1'b0);
    repeat (3) cyc(S_MEMRD, 1'b0, OP_LW, 1'b0);
    cyc(S_MEMRD, 1'b1, OP_LW, 1'b0);
    cyc(S_MEMWB, 1'b1, OP_LW, 1'b0);
    exp_cnt++;

    // BEQ
    fetch_dec(OP_BEQ);
    cyc(S_BEQ, 1'b1, OP_BEQ, 1'b0);
    exp_cnt++;

    // ADDI
    fetch_dec(OP_ADDI);
    cyc(S_ADDIEX, 1'b1, OP_ADDI, 1'b0);
    cyc(S_ADDIWB, 1'b1, OP_ADDI, 1'b0);
    exp_cnt++;

    // Illegal opcode: one-cycle pulse, not counted
    fetch_dec(OP_BAD);
    exp_ill = 1'b1;
    cyc(S_FETCH, 1'b0, OP_RTYPE, 1'b0);
    exp_ill = 1'b0;
    cyc(S_FETCH, 1'b0, OP_RTYPE, 1'b0);

    // BNE: decoded only when the feature is built in
    fetch_dec(OP_BNE);
`ifdef MAINDEC_MC_BNE_EN
    exp_bne = 1'b1;
    cyc(S_BEQ, 1'b1, OP_BNE, 1'b0);
    exp_bne = 1'b0;
    exp_cnt++;
`else
    exp_ill = 1'b1;
    cyc(S_FETCH, 1'b0, OP_RTYPE, 1'b0);
    exp_ill = 1'b0;
`endif

    // SW completing after two wait cycles
    fetch_dec(OP_SW);
    cyc(S_MEMADR, 1'b1, OP_SW, 1'b0);
    repeat (2) cyc(S_MEMWR, 1'b0, OP_SW, 1'b0);
    cyc(S_MEMWR, 1'b1, OP_SW, 1'b0);
    exp_cnt++;

    // 16 jumps: counter passes 15->0 and returns to its start value
    for (int i = 0; i < 16; i++) begin
      fetch_dec(OP_J);
      cyc(S_JUMP, 1'b1, OP_J, 1'b0);
      exp_cnt++;
    end

    // SW never acknowledged: 15 waiting cycles, timeout on the 16th
    fetch_dec(OP_SW);
    cyc(S_MEMADR, 1'b1, OP_SW, 1'b0);
    repeat (MAX_WAIT) cyc(S_MEMWR, 1'b0, OP_SW, 1'b0);
    cyc(S_MEMWR, 1'b0, OP_SW, 1'b1);
    exp_to = 1'b1;
    cyc(S_FETCH, 1'b0, OP_SW, 1'b0);

    // Timeout flag stays set across a later normal instruction
    fetch_dec(OP_RTYPE);
    cyc(S_EXEC, 1'b1, OP_RTYPE, 1'b0);
    cyc(S_ALUWB, 1'b1, OP_RTYPE, 1'b0);
    exp_cnt++;
    cyc(S_FETCH, 1'b0, OP_RTYPE, 1'b0);

    // Reset during MEMWR: no write that cycle, clean FETCH afterwards
    fetch_dec(OP_SW);
    cyc(S_MEMADR, 1'b1, OP_SW, 1'b0);
    rst_v = 1'b1;
    cyc(S_MEMWR, 1'b0, OP_SW, 1'b0);
    rst_v   = 1'b0;
    exp_cnt = '0;
    exp_to  = 1'b0;
    cyc(S_FETCH, 1'b0, OP_RTYPE, 1'b0);
    cyc(S_FETCH, 1'b1, OP_RTYPE, 1'b0);

    @(posedge clk);
    @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending records expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
